// File: rtl/serial_alu_nbit.sv
// Digit-serial N-bit ALU (AND/OR/ADD/SLT) with start/busy/done handshake.
// Define SERIAL_ALU_SLT_EN to enable op 3 (SLT); otherwise op 3 returns zero.
module serial_alu_nbit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             carryIn,
  input  logic             ainvert,
  input  logic             binvert,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             overflow,
  output logic             zero
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = $clog2(K + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr, b_sr, acc;
  logic [1:0]       op_r;
  logic             carry, c_msb, c_out;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] a_d, b_d, d_res;
  logic [DIGIT:0]   chain;
  logic [WIDTH-1:0] fin_res;
  logic             fin_co, fin_ov;

  // One digit slice: bitwise logic or a ripple add fed by the running carry.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    a_d      = a_sr[DIGIT-1:0];
    b_d      = b_sr[DIGIT-1:0];
    chain    = '0;
    chain[0] = carry;
    d_res    = '0;
    for (int i = 0; i < DIGIT; i++) begin
      chain[i+1] = (a_d[i] & b_d[i]) | (chain[i] & (a_d[i] ^ b_d[i]));
    end
    case (op_r)
      2'd0:    d_res = a_d & b_d;
      2'd1:    d_res = a_d | b_d;
      default: d_res = a_d ^ b_d ^ chain[DIGIT-1:0];
    endcase
  end

  // Final result and flags, formed from the assembled accumulator.
  always_comb begin
    fin_res = acc;
    fin_co  = 1'b0;
    fin_ov  = 1'b0;
    case (op_r)
      2'd2: begin
        fin_co = c_out;
        fin_ov = c_msb ^ c_out;
      end
      2'd3: begin
`ifdef SERIAL_ALU_SLT_EN
        fin_co  = c_out;
        fin_ov  = c_msb ^ c_out;
        fin_res = {{(WIDTH-1){1'b0}}, acc[WIDTH-1] ^ (c_msb ^ c_out)};
`else
        fin_res = '0;
`endif
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      acc      <= '0;
      op_r     <= '0;
      carry    <= 1'b0;
      c_msb    <= 1'b0;
      c_out    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carryOut <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= ainvert ? ~in1 : in1;
            b_sr  <= binvert ? ~in2 : in2;
            carry <= carryIn;
            op_r  <= op;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (cnt == CW'(K)) begin
            result   <= fin_res;
            carryOut <= fin_co;
            overflow <= fin_ov;
            zero     <= (fin_res == '0);
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_DONE;
          end else begin
            acc  <= WIDTH'({d_res, acc} >> DIGIT);
            a_sr <= a_sr >> DIGIT;
            b_sr <= b_sr >> DIGIT;
            if (op_r[1]) carry <= chain[DIGIT];
            if (cnt == CW'(K - 1)) begin
              c_msb <= chain[DIGIT-1];
              c_out <= chain[DIGIT];
            end
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_nbit.sv
// Self-checking bench for serial_alu_nbit at WIDTH=8, DIGIT=2 against an
// arithmetic reference model; honours SERIAL_ALU_SLT_EN like the design.
module tb_serial_alu_nbit;

  localparam int W = 8;
  localparam int D = 2;
  localparam int K = W / D;

  typedef struct packed {
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start, carryIn, ainvert, binvert;
  logic [1:0]   op;
  logic [W-1:0] in1, in2;
  logic         busy, done, carryOut, overflow, zero;
  logic [W-1:0] result;

  int   checks = 0;
  int   errors = 0;
  exp_t last;

  always #5 clk = ~clk;

  serial_alu_nbit #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .carryIn(carryIn), .ainvert(ainvert), .binvert(binvert), .op(op),
    .busy(busy), .done(done), .result(result), .carryOut(carryOut),
    .overflow(overflow), .zero(zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic ai, input logic bi,
                                 input logic [1:0] o);
    logic [W-1:0] a, b, s;
    logic [W:0]   full;
    logic         ov;
    exp_t         e;
    a    = ai ? ~x : x;
    b    = bi ? ~y : y;
    full = (W+1)'(a) + (W+1)'(b) + (W+1)'(ci);
    s    = full[W-1:0];
    ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    e    = '0;
    case (o)
      2'd0: e.r = a & b;
      2'd1: e.r = a | b;
      2'd2: begin e.r = s; e.co = full[W]; e.ov = ov; end
      default: begin
`ifdef SERIAL_ALU_SLT_EN
        e.r  = (s[W-1] ^ ov) ? W'(1) : W'(0);
        e.co = full[W];
        e.ov = ov;
`else
        e.r = '0;
`endif
      end
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic ai, input logic bi,
                        input logic [1:0] o, input bit mid_start);
    exp_t e;
    int   lat;
    bit   stable;
    e = model(x, y, ci, ai, bi, o);
    @(negedge clk);
    in1 = x; in2 = y; carryIn = ci; ainvert = ai; binvert = bi; op = o; start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy_start"}, busy, 1);
    start = 1'b0;
    in1 = W'($urandom); in2 = W'($urandom); carryIn = 1'($urandom);
    ainvert = 1'($urandom); binvert = 1'($urandom); op = 2'($urandom);
    lat = 0;
    stable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
      if (!busy || result !== last.r || zero !== last.z ||
          carryOut !== last.co || overflow !== last.ov) stable = 1'b0;
      if (mid_start && i == 2) start = 1'b1;
      if (mid_start && i == 3) start = 1'b0;
    end
    check({tag, "_latency"}, lat, K + 1);
    check({tag, "_stable_busy"}, stable, 1);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_result"}, result, e.r);
    check({tag, "_carryout"}, carryOut, e.co);
    check({tag, "_overflow"}, overflow, e.ov);
    check({tag, "_zero"}, zero, e.z);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    last = e;
  endtask

  initial begin
    exp_t e;
    int   t[$];
    bit   seen;
    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
    carryIn = 1'b0; ainvert = 1'b0; binvert = 1'b0; op = '0;
    last = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flags", {carryOut, overflow, zero}, 0);
    @(negedge clk); rst = 1'b0;

    run_op("and",      8'hF0, 8'h3C, 0, 0, 0, 2'd0, 0);
    run_op("add_ovf",  8'h7F, 8'h01, 0, 0, 0, 2'd2, 0);
    run_op("add_wrap", 8'hFF, 8'h01, 0, 0, 0, 2'd2, 0);
    run_op("sub_eq",   8'h05, 8'h05, 1, 0, 1, 2'd2, 0);
    run_op("nor",      8'h0F, 8'h30, 0, 1, 1, 2'd0, 0);
    run_op("or",       8'hA0, 8'h05, 0, 0, 0, 2'd1, 0);
    run_op("slt_neg",  8'h80, 8'h01, 1, 0, 1, 2'd3, 0);
    run_op("slt_pos",  8'h01, 8'h80, 1, 0, 1, 2'd3, 0);
    run_op("mid_start", 8'h21, 8'h13, 0, 0, 0, 2'd2, 1);

    for (int n = 0; n < 24; n++) begin
      run_op($sformatf("rnd%0d", n), W'($urandom), W'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), 0);
    end

    // Start held high: one operation every K+2 cycles.
    e = model(8'h12, 8'h34, 0, 0, 0, 2'd2);
    @(negedge clk);
    in1 = 8'h12; in2 = 8'h34; carryIn = 0; ainvert = 0; binvert = 0; op = 2'd2; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk); #1;
      if (done) begin
        t.push_back(c);
        check("b2b_result", result, e.r);
      end
    end
    start = 1'b0;
    check("b2b_count", t.size(), 3);
    check("b2b_first", (t.size() > 0) ? t[0] : -1, K + 1);
    check("b2b_gap1", (t.size() > 1) ? t[1] - t[0] : -1, K + 2);
    check("b2b_gap2", (t.size() > 2) ? t[2] - t[1] : -1, K + 2);
    last = e;
    repeat (2) @(posedge clk);

    // Reset mid-operation.
    @(negedge clk);
    in1 = 8'h0F; in2 = 8'h01; op = 2'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_flags", {carryOut, overflow, zero}, 0);
    @(negedge clk); rst = 1'b0;
    last = '0;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
    check("mid_rst_no_done", seen, 0);
    run_op("after_rst", 8'h40, 8'h02, 1, 0, 0, 2'd2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_alu_nbit.md
# serial_alu_nbit

Multi-cycle, parametrised N-bit ALU built from the same per-bit controls as our 1-bit ALU (ainvert, binvert, carryIn, 2-bit op). Operands are processed DIGIT bits per clock, least-significant digit first, so one small adder slice serves any WIDTH. A start/busy/done handshake lets it sit as a shared arithmetic unit beside the datapath. Result, carryOut, overflow and zero are registered and held until the next operation.

## Interface
- WIDTH, 32: operand/result width in bits; must be ≥2 and a multiple of DIGIT.
- DIGIT, 4: bits processed per cycle; K = WIDTH/DIGIT compute cycles.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request; sampled only when busy=0.
- in1  input  WIDTH  operand a.
- in2  input  WIDTH  operand b.
- carryIn  input  1  carry into bit 0.
- ainvert  input  1  use ~in1.
- binvert  input  1  use ~in2.
- op  input  2  0 AND, 1 OR, 2 ADD, 3 SLT.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: result/flags just updated.
- result  output  WIDTH  registered result.
- carryOut  output  1  carry out of MSB.
- overflow  output  1  signed overflow.
- zero  output  1  result == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches (ainvert ? ~in1 : in1), (binvert ? ~in2 : in2), carryIn, op into internal registers; digit counter = 0; busy=1; -> RUN.
- RUN: each cycle take low DIGIT bits of both operand shift registers; compute AND, OR, or DIGIT-bit sum with running carry; shift result digit in from MSB side; shift operands right by DIGIT; counter++. After the K-th digit -> DONE.
- Carry register used only for op 2/3; logic ops ignore it.
- Final digit: capture carry into MSB (c_msb) and carry out of MSB (c_out).
- op 2: carryOut=c_out, overflow=c_msb^c_out.
- op 3 (SLT): internal sum computed as for ADD; result = {WIDTH-1 zeros, sum[WIDTH-1]^overflow}; carryOut, overflow from the sum. Caller sets binvert=1, carryIn=1 for a<b.
- op 0/1: carryOut=0, overflow=0.
- zero = (final result == 0) for every op.
- DONE: done=1, busy=0 for exactly one cycle; -> IDLE; start in DONE cycle is accepted (same as IDLE).
- start while busy=1: ignored, no effect on operation in flight.
- Input changes after the start edge have no effect.

## Timing
- Reset values: busy=0, done=0, result=0, carryOut=0, overflow=0, zero=0; state IDLE; internal registers 0.
- Start accepted at edge E0; digits processed at E1..EK; result/flags/done update at EK; done high during cycle after EK... precisely: done rises at EK+1 edge and falls at EK+2. Latency start-edge to done = K+1 cycles.
- busy high from E0 through EK+1 edge (falls when done rises).
- Back-to-back: start held high gives one operation every K+2 cycles.
- Result/flags change only at the edge that raises done; stable otherwise.
- rst asserted at any time, including mid-RUN: immediate return to reset values; aborted operation never raises done.

## Configuration
- SERIAL_ALU_SLT_EN defined: op 3 performs SLT as above.
- Not defined: op 3 is unsupported; operation still takes K+1 cycles and pulses done, with result=0, carryOut=0, overflow=0, zero=1. No SLT logic synthesised.

## Test plan
Bench uses WIDTH=8, DIGIT=2 (K=4).
- AND: in1=0xF0, in2=0x3C, op=0 -> result 0x30, zero=0, carryOut=0; done exactly 5 cycles after start edge, busy high 5 cycles.
- ADD overflow: 0x7F+0x01, carryIn=0, op=2 -> result 0x80, overflow=1, carryOut=0; then 0xFF+0x01 -> 0x00, carryOut=1, overflow=0, zero=1.
- SUB: in1=0x05, in2=0x05, binvert=1, carryIn=1, op=2 -> 0x00, zero=1, carryOut=1, overflow=0; NOR: ainvert=1, binvert=1, op=0, 0x0F/0x30 -> 0xC0.
- SLT (macro on): in1=0x80, in2=0x01, binvert=1, carryIn=1, op=3 -> result 0x01, overflow=1; in1=0x01, in2=0x80 -> 0x00, zero=1. Macro off: same stimulus -> 0x00, zero=1, done still pulses.
- Handshake: second start during busy ignored (result reflects first operands only); start held continuously -> done every 6 cycles.
- Reset: assert rst 2 cycles after start -> busy=0, done=0, result=0 immediately and asynchronously; no done pulse follows; next start completes normally.
